// File: rtl/hmc_token_pkg.sv
// ============================================================================
// Module   : hmc_token_pkg
// Purpose  : Shared constants, token count type and FPW legality check for
//            the HMC TX token controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hmc_token_pkg;

   localparam int RTC_WIDTH   = 5;
   localparam int MAX_TOKEN_W = 10;

   typedef logic [MAX_TOKEN_W-1:0] token_cnt_t;

   function automatic bit fpw_legal(input int fpw);
      return (fpw == 2) || (fpw == 4) || (fpw == 6) || (fpw == 8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hmc_rtc_sum.sv
// ============================================================================
// Module   : hmc_rtc_sum
// Purpose  : Return stage: registered masked sum of per-FLIT RTC token counts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hmc_rtc_sum
   import hmc_token_pkg::*;
#(
   parameter int FPW   = 4,
   parameter int OUT_W = 11
) (
   input  logic                       clk,
   input  logic                       res_n,
   input  logic                       clr,
   input  logic [FPW-1:0]             rtc_valid,
   input  logic [FPW*RTC_WIDTH-1:0]   rtc_tokens,
   output logic [OUT_W-1:0]           sum_q
);

   logic [OUT_W-1:0] sum_d;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < FPW; i++) begin
         if (rtc_valid[i]) begin
            sum_d = sum_d + OUT_W'(rtc_tokens[i*RTC_WIDTH +: RTC_WIDTH]);
         end
      end
      // A reload discards whatever returns were in flight.
      if (clr) begin
         sum_d = '0;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/hmc_tx_token_ctrl.sv
// ============================================================================
// Module   : hmc_tx_token_ctrl
// Purpose  : HMC TX flow-control credit manager; optional occupancy monitor
//            enabled by defining HMC_TOKEN_MON_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hmc_tx_token_ctrl
   import hmc_token_pkg::*;
#(
   parameter int FPW                = 4,
   parameter int LOG_FPW            = 2,
   parameter int LOG_MAX_HMC_TOKENS = 10
) (
   input  logic                          clk,
   input  logic                          res_n,
   input  logic [LOG_MAX_HMC_TOKENS-1:0] cfg_init_tokens,
   input  logic                          init_load,
   input  logic                          req_valid,
   input  logic [LOG_FPW:0]              req_flits,
   output logic                          req_ready,
   input  logic [FPW-1:0]                rtc_valid,
   input  logic [FPW*RTC_WIDTH-1:0]      rtc_tokens,
   output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_avail,
   output logic                          tokens_low,
   output logic                          err_overflow,
   output logic                          err_illegal_req,
   input  logic                          err_clear,
   output logic [LOG_MAX_HMC_TOKENS-1:0] mon_tokens_min,
   output logic [31:0]                   mon_stall_cycles
);

   localparam int TW = LOG_MAX_HMC_TOKENS;
   localparam int SW = LOG_MAX_HMC_TOKENS + 1;
   localparam int NW = LOG_MAX_HMC_TOKENS + 2;
   localparam logic [LOG_FPW:0] FPW_L = FPW[LOG_FPW:0];
   localparam logic [TW-1:0]    FPW_T = FPW[TW-1:0];

   if (!fpw_legal(FPW)) begin : g_fpw_check
      $error("hmc_tx_token_ctrl: FPW must be 2, 4, 6 or 8");
   end

   logic [TW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] ceil_q, ceil_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_ill_q, err_ill_d;
   logic [SW-1:0] ret_sum_q;
   logic [TW-1:0] req_flits_ext;
   logic [TW-1:0] debit;
   logic [NW-1:0] n_full;
   logic          illegal;
   logic          ovf_set;

   hmc_rtc_sum #(
      .FPW   (FPW),
      .OUT_W (SW)
   ) u_rtc_sum (
      .clk        (clk),
      .res_n      (res_n),
      .clr        (init_load),
      .rtc_valid  (rtc_valid),
      .rtc_tokens (rtc_tokens),
      .sum_q      (ret_sum_q)
   );

   assign req_flits_ext = TW'(req_flits);
   assign illegal       = (req_flits > FPW_L);
   // Grant looks only at the settled count; in-flight returns are ignored.
   assign req_ready     = !illegal && (cnt_q >= req_flits_ext);
   assign tokens_avail  = cnt_q;
   assign tokens_low    = (cnt_q < FPW_T);
   assign err_overflow    = err_ovf_q;
   assign err_illegal_req = err_ill_q;

   always_comb begin
      debit   = '0;
      cnt_d   = cnt_q;
      ceil_d  = ceil_q;
      ovf_set = 1'b0;
      if (req_valid && req_ready && !init_load) begin
         debit = req_flits_ext;
      end
      n_full = NW'(cnt_q) - NW'(debit) + NW'(ret_sum_q);
      if (init_load) begin
         cnt_d  = cfg_init_tokens;
         ceil_d = cfg_init_tokens;
      end else if (n_full > NW'(ceil_q)) begin
         cnt_d   = ceil_q;
         ovf_set = 1'b1;
      end else begin
         cnt_d = n_full[TW-1:0];
      end
      err_ovf_d = (err_ovf_q && !err_clear) || ovf_set;
      err_ill_d = (err_ill_q && !err_clear) || (req_valid && illegal);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt_q     <= '0;
         ceil_q    <= '0;
         err_ovf_q <= 1'b0;
         err_ill_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ceil_q    <= ceil_d;
         err_ovf_q <= err_ovf_d;
         err_ill_q <= err_ill_d;
      end
   end

`ifdef HMC_TOKEN_MON_EN
   logic [TW-1:0] mon_min_q, mon_min_d;
   logic [31:0]   mon_stall_q, mon_stall_d;

   always_comb begin
      mon_min_d   = mon_min_q;
      mon_stall_d = mon_stall_q;
      if (init_load) begin
         mon_min_d   = cfg_init_tokens;
         mon_stall_d = '0;
      end else begin
         if (cnt_d < mon_min_q) begin
            mon_min_d = cnt_d;
         end
         if (req_valid && !req_ready && !illegal && (mon_stall_q != '1)) begin
            mon_stall_d = mon_stall_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         mon_min_q   <= '1;
         mon_stall_q <= '0;
      end else begin
         mon_min_q   <= mon_min_d;
         mon_stall_q <= mon_stall_d;
      end
   end

   assign mon_tokens_min   = mon_min_q;
   assign mon_stall_cycles = mon_stall_q;
`else
   assign mon_tokens_min   = '0;
   assign mon_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hmc_tx_token_ctrl.sv
// ============================================================================
// Module   : tb_hmc_tx_token_ctrl
// Purpose  : Directed self-checking bench for hmc_tx_token_ctrl (FPW=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hmc_tx_token_ctrl;

   logic        clk = 1'b0;
   logic        res_n;
   logic [9:0]  cfg_init_tokens;
   logic        init_load;
   logic        req_valid;
   logic [2:0]  req_flits;
   logic        req_ready;
   logic [3:0]  rtc_valid;
   logic [19:0] rtc_tokens;
   logic [9:0]  tokens_avail;
   logic        tokens_low;
   logic        err_overflow;
   logic        err_illegal_req;
   logic        err_clear;
   logic [9:0]  mon_tokens_min;
   logic [31:0] mon_stall_cycles;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hmc_tx_token_ctrl #(
      .FPW                (4),
      .LOG_FPW            (2),
      .LOG_MAX_HMC_TOKENS (10)
   ) dut (
      .clk              (clk),
      .res_n            (res_n),
      .cfg_init_tokens  (cfg_init_tokens),
      .init_load        (init_load),
      .req_valid        (req_valid),
      .req_flits        (req_flits),
      .req_ready        (req_ready),
      .rtc_valid        (rtc_valid),
      .rtc_tokens       (rtc_tokens),
      .tokens_avail     (tokens_avail),
      .tokens_low       (tokens_low),
      .err_overflow     (err_overflow),
      .err_illegal_req  (err_illegal_req),
      .err_clear        (err_clear),
      .mon_tokens_min   (mon_tokens_min),
      .mon_stall_cycles (mon_stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks run with them settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_mon_reset(input string tag);
`ifdef HMC_TOKEN_MON_EN
      chk({tag, "_mon_min"}, 32'(mon_tokens_min), 32'd1023);
`else
      chk({tag, "_mon_min"}, 32'(mon_tokens_min), 32'd0);
`endif
      chk({tag, "_mon_stall"}, mon_stall_cycles, 32'd0);
   endtask

   initial begin
      res_n = 1'b0;
      cfg_init_tokens = '0;
      init_load = 1'b0;
      req_valid = 1'b0;
      req_flits = '0;
      rtc_valid = '0;
      rtc_tokens = '0;
      err_clear = 1'b0;
      #2;
      chk("rst_avail", 32'(tokens_avail), 32'd0);
      chk("rst_low", 32'(tokens_low), 32'd1);
      chk("rst_ovf", 32'(err_overflow), 32'd0);
      chk("rst_ill", 32'(err_illegal_req), 32'd0);
      chk("rst_ready_f0", 32'(req_ready), 32'd1);
      req_flits = 3'd4;
      #1;
      chk("rst_ready_f4", 32'(req_ready), 32'd0);
      chk_mon_reset("rst");
      tick();
      res_n = 1'b1;

      // Load 16 tokens, then drain with four 4-FLIT words.
      init_load = 1'b1;
      cfg_init_tokens = 10'd16;
      req_valid = 1'b0;
      tick();
      init_load = 1'b0;
      chk("init_avail", 32'(tokens_avail), 32'd16);
      chk("init_low", 32'(tokens_low), 32'd0);
      req_valid = 1'b1;
      req_flits = 3'd4;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_ready", 32'(req_ready), 32'd1);
         tick();
         chk("drain_avail", 32'(tokens_avail), 32'(12 - 4 * i));
      end
      #1;
      chk("drain_ready5", 32'(req_ready), 32'd0);
      chk("drain_low", 32'(tokens_low), 32'd1);
      req_valid = 1'b0;

      // Return 4 x 3 tokens: visible two edges later.
      rtc_valid = 4'b1111;
      rtc_tokens = {5'd3, 5'd3, 5'd3, 5'd3};
      tick();
      rtc_valid = '0;
      rtc_tokens = '0;
      chk("ret_t1_avail", 32'(tokens_avail), 32'd0);
      tick();
      chk("ret_t2_avail", 32'(tokens_avail), 32'd12);
      chk("ret_ovf", 32'(err_overflow), 32'd0);

      // Zero-FLIT request: granted, no debit.
      req_valid = 1'b1;
      req_flits = 3'd0;
      #1;
      chk("f0_ready", 32'(req_ready), 32'd1);
      tick();
      chk("f0_avail", 32'(tokens_avail), 32'd12);

      // 12 -> 10, then simultaneous debit 4 and return 2 -> 8.
      req_flits = 3'd2;
      tick();
      chk("deb2_avail", 32'(tokens_avail), 32'd10);
      req_valid = 1'b0;
      rtc_valid = 4'b0001;
      rtc_tokens = {5'd0, 5'd0, 5'd0, 5'd2};
      tick();
      rtc_valid = '0;
      rtc_tokens = '0;
      req_valid = 1'b1;
      req_flits = 3'd4;
      tick();
      req_valid = 1'b0;
      chk("both_avail", 32'(tokens_avail), 32'd8);

      // Return 7 -> 15, then return 5 against ceiling 16.
      rtc_valid = 4'b0010;
      rtc_tokens = {5'd0, 5'd0, 5'd7, 5'd0};
      tick();
      rtc_valid = '0;
      tick();
      chk("pre_ovf_avail", 32'(tokens_avail), 32'd15);
      rtc_valid = 4'b1000;
      rtc_tokens = {5'd5, 5'd0, 5'd0, 5'd0};
      tick();
      rtc_valid = '0;
      rtc_tokens = '0;
      tick();
      chk("ovf_avail", 32'(tokens_avail), 32'd16);
      chk("ovf_flag", 32'(err_overflow), 32'd1);
      tick();
      chk("ovf_sticky", 32'(err_overflow), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("ovf_cleared", 32'(err_overflow), 32'd0);

      // Illegal FLIT count.
      req_valid = 1'b1;
      req_flits = 3'd5;
      #1;
      chk("ill_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("ill_flag", 32'(err_illegal_req), 32'd1);
      chk("ill_avail", 32'(tokens_avail), 32'd16);

      // Reload discards a pending return and ignores a same-cycle grant.
      rtc_valid = 4'b0001;
      rtc_tokens = {5'd0, 5'd0, 5'd0, 5'd3};
      tick();
      rtc_valid = '0;
      rtc_tokens = '0;
      init_load = 1'b1;
      cfg_init_tokens = 10'd20;
      req_valid = 1'b1;
      req_flits = 3'd4;
      tick();
      init_load = 1'b0;
      req_valid = 1'b0;
      chk("reload_avail", 32'(tokens_avail), 32'd20);
      tick();
      chk("reload_nodisc", 32'(tokens_avail), 32'd20);

      // Debit down to 2: 20-4*4=4, then -2.
      req_valid = 1'b1;
      req_flits = 3'd4;
      for (int i = 0; i < 4; i++) tick();
      req_flits = 3'd2;
      tick();
      chk("mon_cnt2", 32'(tokens_avail), 32'd2);
      req_flits = 3'd4;
      for (int i = 0; i < 3; i++) tick();
      req_valid = 1'b0;
      chk("stall_avail", 32'(tokens_avail), 32'd2);
`ifdef HMC_TOKEN_MON_EN
      chk("mon_stall3", mon_stall_cycles, 32'd3);
      chk("mon_min2", 32'(mon_tokens_min), 32'd2);
`else
      chk("mon_stall_off", mon_stall_cycles, 32'd0);
      chk("mon_min_off", 32'(mon_tokens_min), 32'd0);
`endif

      // Asynchronous reset mid-cycle with the illegal flag still set.
      chk("pre_rst_ill", 32'(err_illegal_req), 32'd1);
      #2;
      res_n = 1'b0;
      #1;
      chk("arst_avail", 32'(tokens_avail), 32'd0);
      chk("arst_low", 32'(tokens_low), 32'd1);
      chk("arst_ill", 32'(err_illegal_req), 32'd0);
      chk("arst_ovf", 32'(err_overflow), 32'd0);
      chk_mon_reset("arst");
      tick();
      res_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
